fp64_to_int64: RTL

- Multi-cycle converter from an IEEE-754 double into a signed 64-bit integer, rounding toward zero.
- It is the decode direction of the FPU datapath: it unpacks the {sign, 11-bit exponent, 52-bit mantissa} format that the add/sub unit packs, and denormalises the significand into an integer.
- An iterative barrel shifter keeps the area small; the same clk/enable clock-enable convention as the other FPU units applies.

---
 rtl/fp64_to_int64.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fp64_to_int64.sv
// IEEE-754 double to signed 64-bit integer, truncating toward zero.
// The significand is aligned by an iterative shifter, at most STEP bits per cycle.
module fp64_to_int64 #(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        start,
    input  logic [63:0] a_operand,
    output logic        busy,
    output logic        done,
    output logic [63:0] Result,
    output logic        Exception,
    output logic        Inexact
);

    typedef enum logic [1:0] {IDLE, ALIGN, FINISH} state_t;

    localparam logic [5:0] STEP_AMT = 6'(STEP);

    state_t      state_reg, state_next;
    logic [63:0] work_reg, work_next;
    logic [5:0]  rem_reg, rem_next;
    logic        left_reg, left_next;
    logic        sign_reg, sign_next;
    logic        special_reg, special_next;
    logic        exc_reg, exc_next;
    logic        sticky_reg, sticky_next;
    logic [63:0] result_reg, result_next;
    logic        exc_out_reg, exc_out_next;
    logic        inexact_out_reg, inexact_out_next;
    logic        done_reg, done_next;

    logic [10:0] exp_field;
    logic [51:0] mant_field;
    logic [5:0]  step_amt;
    logic [63:0] drop_mask;

    assign exp_field  = a_operand[62:52];
    assign mant_field = a_operand[51:0];
    assign step_amt   = (rem_reg < STEP_AMT) ? rem_reg : STEP_AMT;
    assign drop_mask  = (64'd1 << step_amt) - 64'd1;

    always_comb begin
        state_next       = state_reg;
        work_next        = work_reg;
        rem_next         = rem_reg;
        left_next        = left_reg;
        sign_next        = sign_reg;
        special_next     = special_reg;
        exc_next         = exc_reg;
        sticky_next      = sticky_reg;
        result_next      = result_reg;
        exc_out_next     = exc_out_reg;
        inexact_out_next = inexact_out_reg;
        done_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sign_next    = a_operand[63];
                    special_next = 1'b0;
                    exc_next     = 1'b0;
                    sticky_next  = 1'b0;
                    left_next    = 1'b0;
                    rem_next     = 6'd0;
                    work_next    = {11'b0, |exp_field, mant_field};
                    if (exp_field == 11'd2047) begin
                        special_next = 1'b1;
                        exc_next     = 1'b1;
                        work_next    = 64'd0;
                    end else if (exp_field == 11'd0) begin
                        special_next = 1'b1;
                        sticky_next  = |mant_field;
                        work_next    = 64'd0;
                    end else if (exp_field < 11'd1023) begin
                        special_next = 1'b1;
                        sticky_next  = 1'b1;
                        work_next    = 64'd0;
                    end else if (exp_field >= 11'd1086) begin
                        special_next = 1'b1;
                        // -2^63 is the only representable value at this magnitude
                        if (a_operand[63] && exp_field == 11'd1086 && mant_field == 52'd0) begin
                            work_next = 64'h8000_0000_0000_0000;
                        end else begin
                            exc_next  = 1'b1;
                            work_next = 64'd0;
                        end
                    end else if (exp_field <= 11'd1075) begin
                        // 1075 = 1023 + 52; only the low 6 bits of the distance matter
                        rem_next = 6'd51 - exp_field[5:0];
                    end else begin
                        left_next = 1'b1;
                        rem_next  = exp_field[5:0] - 6'd51;
                    end
                    state_next = (special_next || rem_next == 6'd0) ? FINISH : ALIGN;
                end
            end
            ALIGN: begin
                if (left_reg) begin
                    work_next = work_reg << step_amt;
                end else begin
                    work_next   = work_reg >> step_amt;
                    sticky_next = sticky_reg | (|(work_reg & drop_mask));
                end
                rem_next = rem_reg - step_amt;
                if (rem_next == 6'd0) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                result_next      = (sign_reg && !special_reg) ? (64'd0 - work_reg) : work_reg;
                exc_out_next     = exc_reg;
                inexact_out_next = sticky_reg;
                done_next        = 1'b1;
                state_next       = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            work_reg        <= 64'd0;
            rem_reg         <= 6'd0;
            left_reg        <= 1'b0;
            sign_reg        <= 1'b0;
            special_reg     <= 1'b0;
            exc_reg         <= 1'b0;
            sticky_reg      <= 1'b0;
            result_reg      <= 64'd0;
            exc_out_reg     <= 1'b0;
            inexact_out_reg <= 1'b0;
            done_reg        <= 1'b0;
        end else if (enable) begin
            state_reg       <= state_next;
            work_reg        <= work_next;
            rem_reg         <= rem_next;
            left_reg        <= left_next;
            sign_reg        <= sign_next;
            special_reg     <= special_next;
            exc_reg         <= exc_next;
            sticky_reg      <= sticky_next;
            result_reg      <= result_next;
            exc_out_reg     <= exc_out_next;
            inexact_out_reg <= inexact_out_next;
            done_reg        <= done_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign Result    = result_reg;
    assign Exception = exc_out_reg;
    assign Inexact   = inexact_out_reg;

endmodule
